// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the read-only memory port, buffers {word, pc}
// pairs in a small FIFO, and hands them to decode over a valid/ready handshake.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_FETCH | pc in range: fetch one word per cycle while the FIFO has room
// ST_FAULT | pc left the legal window: no fetches, queue drains, wait redirect
module fetch_unit #(
  parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
  parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write,
  output logic [31:0] mem_data_in,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] LAST_ADDR = STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {ST_FETCH, ST_FAULT} state_t;

  state_t           state, state_nxt;
  logic [31:0]      pc;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [31:0]      word_q [FIFO_DEPTH];
  logic [31:0]      pc_q   [FIFO_DEPTH];
  logic             in_range, push, pop;
  logic             redirect_lsb_unused;

  assign in_range = (pc >= STARTING_ADDR) && (pc <= LAST_ADDR);
  assign pop      = inst_valid && inst_ready;
  assign push     = (state == ST_FETCH) && in_range && !redirect_valid &&
                    ((count < FULL_CNT) || pop);

  // Word alignment is enforced by dropping the low address bits.
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid)                        state_nxt = ST_FETCH;
    else if (state == ST_FETCH && !in_range)   state_nxt = ST_FAULT;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= STARTING_ADDR;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // Flush wins over any same-cycle handshake from decode.
      pc     <= {redirect_pc[31:2], 2'b00};
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        word_q[wr_ptr] <= mem_data_out;
        pc_q[wr_ptr]   <= pc;
        pc             <= pc + 32'd4;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign mem_address    = pc;
  assign mem_read_write = 1'b0;
  assign mem_data_in    = 32'h0;
  assign inst_valid     = (count != '0);
  assign inst           = word_q[rd_ptr];
  assign inst_pc        = pc_q[rd_ptr];
  assign fetch_fault    = (state == ST_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural memory feeds the DUT and an
// expected-PC queue is compared against every instruction decode accepts.
module tb_fetch_unit;

  localparam logic [31:0] START = 32'h0100_0000;

  logic        clock;
  logic        reset_n;
  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic        mem_read_write;
  logic [31:0] mem_data_in;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  fetch_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .mem_address    (mem_address),
    .mem_data_out   (mem_data_out),
    .mem_read_write (mem_read_write),
    .mem_data_in    (mem_data_in),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  assign mem_data_out = mem_word(mem_address);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    n_checks++;
    if (mem_read_write !== 1'b0 || mem_data_in !== 32'h0) begin
      n_fail++;
      $display("FAIL bus_const: rw=%b data_in=%h required rw=0 data_in=0", mem_read_write, mem_data_in);
    end
  end

  task automatic do_reset;
    reset_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clock); @(negedge clock);
    n_checks++; if (mem_address !== START) begin n_fail++; $display("FAIL rst_addr: got %h want %h", mem_address, START); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
    n_checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_fifo: inst=%h pc=%h want 0/0", inst, inst_pc); end
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
  endtask

  task automatic test_free_run;
    do_reset();
    inst_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(START + 32'(4 * i));
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL fr_first_valid: got %b at release want 0", inst_valid); end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL fr_valid: cycle %0d got %b want 1", i, inst_valid); end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL fr_underflow: got pc %h want none", inst_pc); end
        else begin
          e = exp_q.pop_front();
          n_checks++; if (inst_pc !== e) begin n_fail++; $display("FAIL fr_pc: got %h want %h", inst_pc, e); end
          n_checks++; if (inst !== mem_word(e)) begin n_fail++; $display("FAIL fr_inst: got %h want %h", inst, mem_word(e)); end
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fr_leftover: got %0d want 0", exp_q.size()); end
    inst_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(START + 32'(4 * i));
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (i >= 4) begin
        n_checks++; if (mem_address !== START + 32'h10) begin n_fail++; $display("FAIL bp_freeze: cycle %0d got %h want %h", i, mem_address, START + 32'h10); end
      end
      n_checks++; if (inst_pc !== START) begin n_fail++; $display("FAIL bp_head_stable: got %h want %h", inst_pc, START); end
    end
    inst_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: step %0d got %b want 1", j, inst_valid); end
      n_checks++; if (mem_address !== START + 32'h10 + 32'(4 * j)) begin n_fail++; $display("FAIL bp_pushpop_addr: got %h want %h", mem_address, START + 32'h10 + 32'(4 * j)); end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL bp_underflow: got pc %h want none", inst_pc); end
        else begin
          e = exp_q.pop_front();
          n_checks++; if (inst_pc !== e) begin n_fail++; $display("FAIL bp_pc: got %h want %h", inst_pc, e); end
          n_checks++; if (inst !== mem_word(e)) begin n_fail++; $display("FAIL bp_inst: got %h want %h", inst, mem_word(e)); end
        end
      end
      @(negedge clock);
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect;
    do_reset();
    @(negedge clock); @(negedge clock); @(negedge clock);
    n_checks++; if (mem_address !== START + 32'hC) begin n_fail++; $display("FAIL rd_pre_addr: got %h want %h", mem_address, START + 32'hC); end
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0042; inst_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h0100_0040 + 32'(4 * i));
    @(negedge clock);
    redirect_valid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rd_flush: got valid %b want 0", inst_valid); end
    n_checks++; if (mem_address !== 32'h0100_0040) begin n_fail++; $display("FAIL rd_addr: got %h want 01000040", mem_address); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid: step %0d got %b want 1", j, inst_valid); end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL rd_underflow: got pc %h want none", inst_pc); end
        else begin
          e = exp_q.pop_front();
          n_checks++; if (inst_pc !== e) begin n_fail++; $display("FAIL rd_pc: got %h want %h", inst_pc, e); end
          n_checks++; if (inst !== mem_word(e)) begin n_fail++; $display("FAIL rd_inst: got %h want %h", inst, mem_word(e)); end
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rd_leftover: got %0d want 0", exp_q.size()); end
    inst_ready = 1'b0;
  endtask

  task automatic test_range_fault;
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h010F_FFF8;
    exp_q.delete();
    exp_q.push_back(32'h010F_FFF8);
    exp_q.push_back(32'h010F_FFFC);
    @(negedge clock);
    redirect_valid = 1'b0;
    n_checks++; if (mem_address !== 32'h010F_FFF8) begin n_fail++; $display("FAIL flt_addr: got %h want 010FFFF8", mem_address); end
    for (int j = 0; j < 2; j++) begin
      @(negedge clock);
      n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL flt_early: step %0d got %b want 0", j, fetch_fault); end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL flt_underflow: got pc %h want none", inst_pc); end
        else begin
          e = exp_q.pop_front();
          n_checks++; if (inst_pc !== e) begin n_fail++; $display("FAIL flt_pc: got %h want %h", inst_pc, e); end
          n_checks++; if (inst !== mem_word(e)) begin n_fail++; $display("FAIL flt_inst: got %h want %h", inst, mem_word(e)); end
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL flt_leftover: got %0d want 0", exp_q.size()); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      n_checks++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL flt_sticky: step %0d got %b want 1", j, fetch_fault); end
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL flt_drained: got %b want 0", inst_valid); end
      n_checks++; if (mem_address !== 32'h0110_0000) begin n_fail++; $display("FAIL flt_pc_hold: got %h want 01100000", mem_address); end
    end
    redirect_valid = 1'b1; redirect_pc = START;
    @(negedge clock);
    redirect_valid = 1'b0;
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL flt_clear: got %b want 0", fetch_fault); end
    n_checks++; if (mem_address !== START) begin n_fail++; $display("FAIL flt_clear_addr: got %h want %h", mem_address, START); end
    exp_q.push_back(START);
    @(negedge clock);
    if (inst_valid && inst_ready) begin
      e = exp_q.pop_front();
      n_checks++; if (inst_pc !== e) begin n_fail++; $display("FAIL flt_resume_pc: got %h want %h", inst_pc, e); end
    end else begin
      n_checks++; n_fail++; $display("FAIL flt_resume_valid: got %b want 1", inst_valid);
    end
    // Just below the window faults on the very next edge.
    redirect_valid = 1'b1; redirect_pc = 32'h00FF_FFFC;
    @(negedge clock);
    redirect_valid = 1'b0;
    n_checks++; if (fetch_fault !== 1'b0 || mem_address !== 32'h00FF_FFFC) begin n_fail++; $display("FAIL low_redirect: fault=%b addr=%h want 0/00FFFFFC", fetch_fault, mem_address); end
    @(negedge clock);
    n_checks++; if (fetch_fault !== 1'b1 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL low_fault: fault=%b valid=%b want 1/0", fetch_fault, inst_valid); end
    inst_ready = 1'b0;
  endtask

  task automatic test_full_pushpop_reset;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(START + 32'(4 * i));
    for (int i = 0; i < 5; i++) @(negedge clock);
    inst_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      n_checks++; if (mem_address !== START + 32'h10 + 32'(4 * j)) begin n_fail++; $display("FAIL full_addr: got %h want %h", mem_address, START + 32'h10 + 32'(4 * j)); end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL full_underflow: got pc %h want none", inst_pc); end
        else begin
          e = exp_q.pop_front();
          n_checks++; if (inst_pc !== e) begin n_fail++; $display("FAIL full_pc: got %h want %h", inst_pc, e); end
          n_checks++; if (inst !== mem_word(e)) begin n_fail++; $display("FAIL full_inst: got %h want %h", inst, mem_word(e)); end
        end
      end else begin
        n_checks++; n_fail++; $display("FAIL full_valid: got %b want 1", inst_valid);
      end
      @(negedge clock);
    end
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b want 0", inst_valid); end
    n_checks++; if (mem_address !== START) begin n_fail++; $display("FAIL async_rst_addr: got %h want %h", mem_address, START); end
    @(negedge clock);
    reset_n = 1'b1; inst_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect();
    test_range_fault();
    test_full_pushpop_reset();
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
